uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO between the CPU-side UART MMIO write (0x8000_0004) and the uart_tx
//  serializer. Software writes bytes without polling per byte; the drain FSM feeds
//  the serializer with a single-cycle tx_start pulse and obeys tx_busy.
//  Exposes full/overflow/busy for the MMIO status read (0x8000_0008).
// PARAMETERS
//  DEPTH        16  FIFO entries; power of two, >= 2
//  DATA_W       8   byte width
//  LAUNCH_TMO   4   cycles LAUNCH waits for tx_busy to rise before giving up
// PORTS
//  clk          in   1                  system clock; all logic on posedge
//  rst          in   1                  synchronous, active-high reset
//  wr_en        in   1                  MMIO byte write strobe (one cycle per byte)
//  wr_data      in   DATA_W             byte to enqueue
//  clr_overflow in   1                  clears sticky overflow
//  full         out  1                  count == DEPTH
//  empty        out  1                  count == 0
//  count        out  $clog2(DEPTH+1)    current occupancy
//  overflow     out  1                  sticky: a write was dropped
//  busy         out  1                  !empty | state!=IDLE | tx_busy (SW status bit 0)
//  tx_start     out  1                  one-cycle launch pulse to serializer
//  tx_data      out  DATA_W             byte to serializer; stable from pulse until IDLE
//  tx_busy      in   1                  serializer busy
// BEHAVIOUR
//  Reset: rst at a posedge gives count=0, empty=1, full=0, overflow=0, tx_start=0,
//   tx_data=0, state=IDLE. Read/write pointers go to 0. Queued bytes are discarded.
//   rst mid-transmission does the same. The serializer is reset by the same rst.
//  Storage: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   count is tracked separately; no "extra pointer bit" scheme.
//  Write: accepted iff wr_en & !full, where full is the registered value.
//   A write that arrives when full is rejected even if a pop happens in the same
//   cycle. A rejected write does not change mem, wr_ptr or count, and sets overflow.
//  overflow: set on a rejected write, cleared by clr_overflow. Set wins when both
//   occur in the same cycle.
//  Pop: occurs only on the IDLE->LAUNCH transition.
//   Simultaneous accepted write and pop leaves count unchanged; both pointers advance.
//  Drain FSM (all outputs registered):
//   IDLE:   if !empty & !tx_busy, then on the next edge:
//           tx_data<=mem[rd_ptr], tx_start<=1, rd_ptr++, go LAUNCH.
//   LAUNCH: tx_start<=0. If tx_busy, go DRAIN.
//           Otherwise, after LAUNCH_TMO cycles in LAUNCH, go IDLE.
//           The byte counts as sent and no retry is made.
//   DRAIN:  when !tx_busy, go IDLE.
//  tx_start is never high on two consecutive cycles, and never high while tx_busy
//   was high in the previous cycle.
//  Latency: a byte accepted at edge k into an empty FIFO, with the serializer idle,
//   gives tx_start=1 during the cycle after edge k+1.
//   The minimum spacing between pulses is pulse, LAUNCH, DRAIN(>=1), IDLE, pulse,
//   plus the serializer busy time.
//  Ordering: strictly FIFO. No byte is duplicated. Bytes are lost only by rejection
//   when full, or by rst.
// TESTING
//  1 Empty FIFO, idle serializer. Write 0x41 at edge k.
//    -> count=1 after edge k; tx_start high for exactly one cycle after edge k+1,
//       with tx_data=0x41; count=0 and empty=1 after edge k+1.
//  2 Hold tx_busy=1, then write 0x00..0x0F back-to-back.
//    -> full=1 and count=16 after the 16th write.
//    Release tx_busy -> bytes 0x00..0x0F launched in order, one pulse per byte.
//  3 FIFO full, write 0xAA. -> count stays 16, overflow=1, 0xAA is never transmitted.
//    Then assert clr_overflow -> overflow=0.
//    Assert clr_overflow together with a rejected write -> overflow stays 1.
//  4 FIFO full, wr_en in the same cycle as the IDLE pop.
//    -> write rejected, count=15, overflow=1.
//  5 Stub serializer never raises tx_busy. Write 0x55, 0x66.
//    -> each byte gets one pulse; pulses are separated by LAUNCH_TMO+1 cycles; no hang.
//  6 Three bytes queued, rst asserted while in DRAIN.
//    -> next cycle count=0, empty=1, tx_start=0, tx_data=0, state=IDLE, overflow=0.
//       No further pulses occur until a new write.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// CPU/serializer-side bundle for the UART transmit FIFO.
// The master side is the MMIO writer together with the serializer; the slave side is the FIFO.
interface uart_tx_fifo_if #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              clr_overflow;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              busy;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic              tx_busy;

   modport master (
      output wr_en, wr_data, clr_overflow, tx_busy,
      input  full, empty, count, overflow, busy, tx_start, tx_data
   );

   modport slave (
      input  wr_en, wr_data, clr_overflow, tx_busy,
      output full, empty, count, overflow, busy, tx_start, tx_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART MMIO write port and the uart_tx serializer.
// A drain FSM launches one byte at a time with a single-cycle tx_start pulse.
module uart_tx_fifo #(
   parameter int DEPTH      = 16,
   parameter int DATA_W     = 8,
   parameter int LAUNCH_TMO = 4
) (
   input logic          clk,
   input logic          rst,
   uart_tx_fifo_if.slave f
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(LAUNCH_TMO + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nx;
   logic              full_q;
   logic              empty_q;
   logic              ovf_q;
   logic              start_q;
   logic [DATA_W-1:0] data_q;
   logic [TW-1:0]     tmo;

   logic              wr_ok;
   logic              wr_rej;
   logic              pop;
   logic              tmo_inc;
   logic              tmo_last;

   // full is the registered flag, so a write is refused even when a pop
   // happens on the same edge.
   assign wr_ok    = f.wr_en & ~full_q;
   assign wr_rej   = f.wr_en & full_q;
   assign tmo_last = (tmo == TW'(LAUNCH_TMO - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (!empty_q && !f.tx_busy) begin
               state_nx = LAUNCH;
            end
         end
         LAUNCH: begin
            if (f.tx_busy) begin
               state_nx = DRAIN;
            end else if (tmo_last) begin
               state_nx = IDLE;
            end
         end
         DRAIN: begin
            if (!f.tx_busy) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      pop     = 1'b0;
      tmo_inc = 1'b0;
      unique case (1'b1)
         (state == IDLE):   pop     = (state_nx == LAUNCH);
         (state == LAUNCH): tmo_inc = (state_nx == LAUNCH);
         default: ;
      endcase
   end

   always_comb begin
      cnt_nx = cnt;
      unique case ({wr_ok, pop})
         2'b10:   cnt_nx = cnt + CW'(1);
         2'b01:   cnt_nx = cnt - CW'(1);
         default: cnt_nx = cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wr_ptr] <= f.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         start_q <= 1'b0;
         data_q  <= '0;
         tmo     <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            data_q <= mem[rd_ptr];
         end
         cnt     <= cnt_nx;
         full_q  <= (cnt_nx == CW'(DEPTH));
         empty_q <= (cnt_nx == '0);
         start_q <= pop;
         tmo     <= tmo_inc ? tmo + TW'(1) : '0;
         if (wr_rej) begin
            ovf_q <= 1'b1;
         end else if (f.clr_overflow) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign f.full     = full_q;
   assign f.empty    = empty_q;
   assign f.count    = cnt;
   assign f.overflow = ovf_q;
   assign f.tx_start = start_q;
   assign f.tx_data  = data_q;
   assign f.busy     = ~empty_q | (state != IDLE) | f.tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a small serializer stub.
// Expected bytes are queued on accepted writes and popped on tx_start.
module tb_uart_tx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_fifo_if #(.DEPTH(16), .DATA_W(8)) f ();

   uart_tx_fifo #(
      .DEPTH(16),
      .DATA_W(8),
      .LAUNCH_TMO(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .f(f)
   );

   always #5 clk = ~clk;

   int        total = 0;
   int        bad   = 0;
   logic [7:0] q[$];

   logic       ser_hold = 1'b0;
   logic       ser_mute = 1'b0;
   logic [3:0] ser_cnt;
   assign f.tx_busy = ser_hold | (ser_cnt != 4'd0);

   always @(posedge clk) begin
      if (rst) begin
         ser_cnt <= 4'd0;
      end else if (f.tx_start && !ser_mute) begin
         ser_cnt <= 4'd3;
      end else if (ser_cnt != 4'd0) begin
         ser_cnt <= ser_cnt - 4'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   int   cyc = 0;
   int   pulses = 0;
   int   last_pulse = 0;
   logic have_last = 1'b0;
   logic gap_on = 1'b0;
   logic prev_start = 1'b0;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!rst && f.tx_start) begin
         chk("dbl_pulse", {31'd0, prev_start}, 0);
         chk("busy_prev", {31'd0, prev_busy}, 0);
         chk("sb_nonempty", (q.size() > 0) ? 1 : 0, 1);
         if (q.size() > 0) begin
            chk("tx_data", {24'd0, f.tx_data}, {24'd0, q.pop_front()});
         end
         if (gap_on && have_last) begin
            chk("gap", cyc - last_pulse, 5);
         end
         last_pulse = cyc;
         have_last  = 1'b1;
         pulses++;
      end
      prev_start = f.tx_start;
      prev_busy  = f.tx_busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] b, input logic push);
      f.wr_en   = 1'b1;
      f.wr_data = b;
      if (push) begin
         q.push_back(b);
      end
      tick();
      f.wr_en = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (f.busy && n < 300) begin
         tick();
         n++;
      end
      chk("idle_tmo", {31'd0, f.busy}, 0);
   endtask

   int p0;

   initial begin
      f.wr_en        = 1'b0;
      f.wr_data      = 8'h00;
      f.clr_overflow = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count", f.count, 0);
      chk("rst_empty", f.empty, 1);
      chk("rst_full", f.full, 0);
      chk("rst_ovf", f.overflow, 0);
      chk("rst_start", f.tx_start, 0);
      chk("rst_data", f.tx_data, 0);
      chk("rst_busy", f.busy, 0);

      // single byte latency
      wr(8'h41, 1'b1);
      chk("t1_count1", f.count, 1);
      chk("t1_nostart", f.tx_start, 0);
      tick();
      chk("t1_start", f.tx_start, 1);
      chk("t1_data", f.tx_data, 8'h41);
      chk("t1_count0", f.count, 0);
      chk("t1_empty", f.empty, 1);
      tick();
      chk("t1_start_low", f.tx_start, 0);
      wait_idle();

      // fill while serializer is held busy
      ser_hold = 1'b1;
      p0 = pulses;
      for (int i = 0; i < 16; i++) begin
         wr(8'(i), 1'b1);
      end
      chk("t2_full", f.full, 1);
      chk("t2_count", f.count, 16);
      chk("t2_nopulse", pulses, p0);

      // overflow handling while full
      wr(8'hAA, 1'b0);
      chk("t3_count", f.count, 16);
      chk("t3_ovf", f.overflow, 1);
      f.clr_overflow = 1'b1;
      tick();
      f.clr_overflow = 1'b0;
      chk("t3_clr", f.overflow, 0);
      f.clr_overflow = 1'b1;
      wr(8'hAA, 1'b0);
      f.clr_overflow = 1'b0;
      chk("t3_set_wins", f.overflow, 1);
      f.clr_overflow = 1'b1;
      tick();
      f.clr_overflow = 1'b0;
      chk("t3_clr2", f.overflow, 0);

      // write collides with the first pop from a full FIFO
      ser_hold  = 1'b0;
      f.wr_en   = 1'b1;
      f.wr_data = 8'hBB;
      tick();
      f.wr_en = 1'b0;
      chk("t4_count", f.count, 15);
      chk("t4_ovf", f.overflow, 1);
      chk("t4_full", f.full, 0);
      wait_idle();
      chk("t2_pulses", pulses - p0, 16);
      chk("t2_sb_empty", q.size(), 0);

      // serializer never answers: launch timeout path
      ser_mute  = 1'b1;
      gap_on    = 1'b1;
      have_last = 1'b0;
      p0 = pulses;
      wr(8'h55, 1'b1);
      wr(8'h66, 1'b1);
      wait_idle();
      chk("t5_pulses", pulses - p0, 2);
      gap_on   = 1'b0;
      ser_mute = 1'b0;

      // reset in the middle of a transfer
      wr(8'hC1, 1'b1);
      wr(8'hC2, 1'b1);
      wr(8'hC3, 1'b1);
      tick();
      chk("t6_busy_pre", f.busy, 1);
      chk("t6_count_pre", f.count, 2);
      rst = 1'b1;
      q.delete();
      tick();
      rst = 1'b0;
      chk("t6_count", f.count, 0);
      chk("t6_empty", f.empty, 1);
      chk("t6_start", f.tx_start, 0);
      chk("t6_data", f.tx_data, 0);
      chk("t6_ovf", f.overflow, 0);
      chk("t6_busy", f.busy, 0);
      p0 = pulses;
      repeat (20) tick();
      chk("t6_quiet", pulses, p0);
      wr(8'h77, 1'b1);
      wait_idle();
      chk("t6_recover", pulses, p0 + 1);
      chk("t6_sb_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
